bambu_offchip_mem_model: RTL and testbench
==========================================

# bambu_offchip_mem_model

Parametrised, synthesizable-style model of the external memory that Bambu-generated `main` accelerators access through their master RAM ports. It serves N_CH independent channels against one shared byte-addressed array, with separate configurable read and write latencies. It applies size-based byte masking and returns per-channel DataRdy. It also adds a preload port, sticky protocol-error flags and deterministic multi-channel write ordering, and sits between the DUT's `Mout_*` ports and the simulation harness.

## Interface
Parameters:
- N_CH, 2, number of memory channels
- ADDR_W, 11, address bits per channel
- DATA_W, 32, data bits per channel (multiple of 8)
- MEM_BYTES, 1024, array depth in bytes
- BASE_ADDR, 0, first mapped byte address
- RD_LAT, 2, read latency in cycles (≥2)
- WR_LAT, 1, write latency in cycles (≥1)
- SIZE_W, 6, bits per channel of the access-size field (size in bits)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- init_we  in  1  preload write strobe
- init_addr  in  ADDR_W  preload byte address (absolute)
- init_data  in  8  preload byte
- m_oe  in  N_CH  read request per channel
- m_we  in  N_CH  write request per channel
- m_addr  in  N_CH*ADDR_W  byte address per channel
- m_wdata  in  N_CH*DATA_W  write data per channel
- m_size  in  N_CH*SIZE_W  access size in bits (8/16/32/...)
- s_rdata  in  N_CH*DATA_W  on-chip slave read data, ORed into m_rdata
- s_datardy  in  N_CH  on-chip slave ready, ORed into m_datardy
- m_rdata  out  N_CH*DATA_W  read data
- m_datardy  out  N_CH  access complete
- err_oe_we  out  N_CH  sticky: oe and we asserted together
- err_oob  out  N_CH  sticky: access straddles top of array

## Operation
- In range: BASE_ADDR ≤ addr < BASE_ADDR+MEM_BYTES. Out-of-range requests are ignored locally: no count, no write, local rdata 0, local datardy 0.
- Request protocol: master holds oe/we, addr, size and wdata stable until datardy is asserted. A request still asserted in the cycle after datardy is a new request.
- Per-channel counter cnt:
  - Read (oe, in range): datardy = (cnt == RD_LAT-1). On that edge cnt←0, otherwise cnt←cnt+1.
  - Write (we, in range): datardy = (cnt == WR_LAT-1). Same counter update.
  - No request: cnt←0.
- Read data path:
  - Combinational little-endian fetch of DATA_W/8 bytes at addr-BASE_ADDR.
  - Passed through an RD_LAT-1 stage delay line; m_rdata is the last stage ORed with s_rdata.
  - Bytes beyond the array read 0.
- Write commit on the clock edge of the write's datardy cycle: mask = (1<<size)-1, and only bytes covered by the mask are updated.
- Same-cycle commits to the same byte from several channels: the highest channel index wins. Preload (init_we) has lowest priority.
- Straddling access: bytes above the top are dropped, err_oob is set for that channel, and the access still completes normally.
- oe&we together on a channel: err_oe_we is set, the request is treated as a read, and no write occurs.
- Error flags clear only on reset.

## Timing
- Reset values: m_datardy 0 (gated by reset), local m_rdata 0, cnt 0, delay lines 0, error flags 0.
- Reset does not clear the memory array, so preloaded data survives reset.
- Reset mid-request: cnt is zeroed and no datardy is produced in the reset cycle. The request restarts from count 0 after reset.
- Read latency: datardy in the RD_LAT-th cycle of the request (cycle index RD_LAT-1); data is valid in the same cycle.
- WR_LAT=1: datardy combinational in the first request cycle.
- A read of a byte committed on edge k returns the new value if the fetch stage samples after k.
- Back-to-back requests: a new request may start in the cycle immediately after datardy, giving one access per RD_LAT/WR_LAT cycles.
- init_we writes on the clock edge. Preload and normal traffic may overlap under the priority rule above.

## Structure
- Package bambu_mem_pkg holds:
  - `size_to_mask(size, DATA_W)` function
  - `clog2` helper
  - in-range check function
  - counter width constant = clog2(max(RD_LAT, WR_LAT))
- Sub-module bambu_mem_chan_ctrl, one instance per channel via generate. It holds the counter, datardy logic, read delay line and error flags.
- The top level owns the byte array, the priority write merge and the preload port.

## Test plan
- Read, default latency: preload bytes 0x10..0x13 = 11,22,33,44; hold oe on ch0 at addr 0x10, size 32 → datardy in cycle 2 (index 1), rdata 0x44332211.
- Masked write: mem 0x20 = 0xAABBCCDD; ch1 we, size 8, wdata 0x000000EE, WR_LAT=1 → datardy same cycle; readback 0xAABBCCEE.
- Write conflict: ch0 and ch1 write 0x11 and 0x22 to byte 0x30 in the same commit cycle → byte reads 0x22.
- Parameter sweep: RD_LAT=4, WR_LAT=3, N_CH=4 → datardy at cycle indices 3 and 2 respectively; back-to-back reads on all channels give one datardy every 4 cycles per channel.
- Boundaries: addr = BASE+MEM_BYTES → no datardy, rdata 0. addr = BASE+MEM_BYTES-2 with size 32 → completes, upper 2 bytes read 0, err_oob=1.
- Errors and reset: oe&we together on ch0 → err_oe_we=1 and memory unchanged. Reset asserted mid-read (RD_LAT=3, cycle 1) → no datardy, flags cleared, memory intact, read completes 3 cycles after reset deasserts.

Source files
------------

// File: rtl/bambu_mem_pkg.sv
// Shared helpers for the off-chip memory model: byte-mask generation,
// address range check and counter sizing.
package bambu_mem_pkg;

    // Upper bound on bytes per channel word that size_to_mask can describe.
    localparam int unsigned MAX_BYTES = 64;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r = 0;
        int unsigned v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Latency counter width: clog2(max(rd_lat, wr_lat)), never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned rd_lat,
                                              input int unsigned wr_lat);
        int unsigned m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return (clog2(m) < 1) ? 1 : clog2(m);
    endfunction

    // True when addr lies inside [base, base+bytes).
    function automatic logic in_range(input int unsigned addr,
                                      input int unsigned base,
                                      input int unsigned bytes);
        return (addr >= base) && (addr < base + bytes);
    endfunction

    // Byte enables for a bit-mask of (1<<size)-1, limited to data_w/8 bytes.
    function automatic logic [MAX_BYTES-1:0] size_to_mask(input int unsigned size,
                                                          input int unsigned data_w);
        logic [MAX_BYTES-1:0] m = '0;
        for (int unsigned b = 0; b < MAX_BYTES; b++) begin
            if ((b < data_w / 8) && (size > 8 * b)) m[b] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bambu_mem_chan_ctrl.sv
// Per-channel request sequencer: latency counter, datardy generation,
// read-data delay line and sticky protocol-error flags.
// Ports: clock/reset; oe/we/addr/size request; fetch = combinational read
// bytes from the array; s_rdata/s_datardy on-chip slave merge; rdata/datardy
// to the master; commit = write lands on this edge; err_oe_we/err_oob sticky.
module bambu_mem_chan_ctrl
    import bambu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SIZE_W    = 6,
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WR_LAT    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              oe,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [SIZE_W-1:0] size,
    input  logic [DATA_W-1:0] fetch,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_datardy,
    output logic [DATA_W-1:0] rdata,
    output logic              datardy,
    output logic              commit,
    output logic              err_oe_we,
    output logic              err_oob
);

    localparam int unsigned CNT_W  = cnt_width(RD_LAT, WR_LAT);
    localparam int unsigned STAGES = RD_LAT - 1;

    logic [CNT_W-1:0]               cnt;
    logic [CNT_W-1:0]               last;
    logic [STAGES-1:0][DATA_W-1:0]  dly;
    logic                           active;
    logic                           done;
    logic                           straddle;
    int unsigned                    off;
    int unsigned                    nbytes;

    // Request decode; oe wins over we so a combined request behaves as a read.
    always_comb begin
        active   = (oe | we) & in_range(32'(addr), BASE_ADDR, MEM_BYTES);
        last     = oe ? CNT_W'(RD_LAT - 1) : CNT_W'(WR_LAT - 1);
        done     = active && (cnt == last);
        off      = 32'(addr) - BASE_ADDR;
        nbytes   = 32'($countones(size_to_mask(32'(size), DATA_W)));
        straddle = active && (off + nbytes > MEM_BYTES);
    end

    assign datardy = ~reset & (done | s_datardy);
    assign commit  = ~reset & done & we & ~oe;
    assign rdata   = dly[STAGES-1] | s_rdata;

    // Counter, delay line and sticky flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            dly       <= '0;
            err_oe_we <= 1'b0;
            err_oob   <= 1'b0;
        end else begin
            cnt    <= (active && !done) ? cnt + CNT_W'(1) : '0;
            dly[0] <= fetch;
            for (int unsigned i = 1; i < STAGES; i++) begin
                dly[i] <= dly[i-1];
            end
            err_oe_we <= err_oe_we | (oe & we);
            err_oob   <= err_oob | straddle;
        end
    end

endmodule

// File: rtl/bambu_offchip_mem_model.sv
// Off-chip memory model shared by N_CH master ports of a Bambu accelerator.
// Ports: clock/reset; init_we/init_addr/init_data byte preload; per-channel
// m_oe/m_we/m_addr/m_wdata/m_size requests; s_rdata/s_datardy on-chip slave
// merge; m_rdata/m_datardy responses; err_oe_we/err_oob sticky error flags.
module bambu_offchip_mem_model
    import bambu_mem_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WR_LAT    = 1,
    parameter int unsigned SIZE_W    = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     init_we,
    input  logic [ADDR_W-1:0]        init_addr,
    input  logic [7:0]               init_data,
    input  logic [N_CH-1:0]          m_oe,
    input  logic [N_CH-1:0]          m_we,
    input  logic [N_CH*ADDR_W-1:0]   m_addr,
    input  logic [N_CH*DATA_W-1:0]   m_wdata,
    input  logic [N_CH*SIZE_W-1:0]   m_size,
    input  logic [N_CH*DATA_W-1:0]   s_rdata,
    input  logic [N_CH-1:0]          s_datardy,
    output logic [N_CH*DATA_W-1:0]   m_rdata,
    output logic [N_CH-1:0]          m_datardy,
    output logic [N_CH-1:0]          err_oe_we,
    output logic [N_CH-1:0]          err_oob
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned IDX_W = clog2(MEM_BYTES);

    logic [7:0]                     mem [MEM_BYTES];
    logic [N_CH-1:0][DATA_W-1:0]    fetch;
    logic [N_CH-1:0][MAX_BYTES-1:0] wmask;
    int unsigned                    woff [N_CH];
    logic [N_CH-1:0]                commit;
    int unsigned                    off;

    // Little-endian fetch per channel; bytes past the array top read 0.
    always_comb begin
        fetch = '0;
        off   = 0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            off = 32'(m_addr[c*ADDR_W +: ADDR_W]) - BASE_ADDR;
            if (m_oe[c] && in_range(32'(m_addr[c*ADDR_W +: ADDR_W]), BASE_ADDR, MEM_BYTES)) begin
                for (int unsigned b = 0; b < BYTES; b++) begin
                    if (off + b < MEM_BYTES) fetch[c][8*b +: 8] = mem[IDX_W'(off + b)];
                end
            end
        end
    end

    // Write byte enables and array offsets per channel.
    always_comb begin
        wmask = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            woff[c]  = 32'(m_addr[c*ADDR_W +: ADDR_W]) - BASE_ADDR;
            wmask[c] = size_to_mask(32'(m_size[c*SIZE_W +: SIZE_W]), DATA_W);
        end
    end

    // Array update: preload first, then channels in ascending order so the
    // highest channel index wins a same-byte collision. Reset leaves contents.
    always_ff @(posedge clock) begin
        if (init_we && in_range(32'(init_addr), BASE_ADDR, MEM_BYTES)) begin
            mem[IDX_W'(32'(init_addr) - BASE_ADDR)] <= init_data;
        end
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (commit[c]) begin
                for (int unsigned b = 0; b < BYTES; b++) begin
                    if (wmask[c][b] && (woff[c] + b < MEM_BYTES)) begin
                        mem[IDX_W'(woff[c] + b)] <= m_wdata[c*DATA_W + 8*b +: 8];
                    end
                end
            end
        end
    end

    // One sequencer per channel.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        bambu_mem_chan_ctrl #(
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .SIZE_W   (SIZE_W),
            .MEM_BYTES(MEM_BYTES),
            .BASE_ADDR(BASE_ADDR),
            .RD_LAT   (RD_LAT),
            .WR_LAT   (WR_LAT)
        ) u_ctrl (
            .clock    (clock),
            .reset    (reset),
            .oe       (m_oe[c]),
            .we       (m_we[c]),
            .addr     (m_addr[c*ADDR_W +: ADDR_W]),
            .size     (m_size[c*SIZE_W +: SIZE_W]),
            .fetch    (fetch[c]),
            .s_rdata  (s_rdata[c*DATA_W +: DATA_W]),
            .s_datardy(s_datardy[c]),
            .rdata    (m_rdata[c*DATA_W +: DATA_W]),
            .datardy  (m_datardy[c]),
            .commit   (commit[c]),
            .err_oe_we(err_oe_we[c]),
            .err_oob  (err_oob[c])
        );
    end

endmodule

// File: tb/tb_bambu_offchip_mem_model.sv
// Directed bench for bambu_offchip_mem_model: default (2 ch, RD 2, WR 1),
// sweep (4 ch, RD 4, WR 3) and reset-mid-read (1 ch, RD 3) instances.
module tb_bambu_offchip_mem_model;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults
    logic         a_reset, a_init_we;
    logic [10:0]  a_init_addr;
    logic [7:0]   a_init_data;
    logic [1:0]   a_oe, a_we, a_s_datardy, a_datardy, a_err_oe_we, a_err_oob;
    logic [21:0]  a_addr;
    logic [63:0]  a_wdata, a_s_rdata, a_rdata;
    logic [11:0]  a_size;

    // Instance B: 4 channels, RD_LAT 4, WR_LAT 3
    logic         b_reset, b_init_we;
    logic [10:0]  b_init_addr;
    logic [7:0]   b_init_data;
    logic [3:0]   b_oe, b_we, b_s_datardy, b_datardy, b_err_oe_we, b_err_oob;
    logic [43:0]  b_addr;
    logic [127:0] b_wdata, b_s_rdata, b_rdata;
    logic [23:0]  b_size;

    // Instance C: 1 channel, RD_LAT 3
    logic         c_reset, c_init_we;
    logic [10:0]  c_init_addr;
    logic [7:0]   c_init_data;
    logic [0:0]   c_oe, c_we, c_s_datardy, c_datardy, c_err_oe_we, c_err_oob;
    logic [10:0]  c_addr;
    logic [31:0]  c_wdata, c_s_rdata, c_rdata;
    logic [5:0]   c_size;

    bambu_offchip_mem_model u_a (
        .clock(clk), .reset(a_reset), .init_we(a_init_we), .init_addr(a_init_addr),
        .init_data(a_init_data), .m_oe(a_oe), .m_we(a_we), .m_addr(a_addr),
        .m_wdata(a_wdata), .m_size(a_size), .s_rdata(a_s_rdata), .s_datardy(a_s_datardy),
        .m_rdata(a_rdata), .m_datardy(a_datardy), .err_oe_we(a_err_oe_we), .err_oob(a_err_oob)
    );

    bambu_offchip_mem_model #(.N_CH(4), .RD_LAT(4), .WR_LAT(3)) u_b (
        .clock(clk), .reset(b_reset), .init_we(b_init_we), .init_addr(b_init_addr),
        .init_data(b_init_data), .m_oe(b_oe), .m_we(b_we), .m_addr(b_addr),
        .m_wdata(b_wdata), .m_size(b_size), .s_rdata(b_s_rdata), .s_datardy(b_s_datardy),
        .m_rdata(b_rdata), .m_datardy(b_datardy), .err_oe_we(b_err_oe_we), .err_oob(b_err_oob)
    );

    bambu_offchip_mem_model #(.N_CH(1), .RD_LAT(3)) u_c (
        .clock(clk), .reset(c_reset), .init_we(c_init_we), .init_addr(c_init_addr),
        .init_data(c_init_data), .m_oe(c_oe), .m_we(c_we), .m_addr(c_addr),
        .m_wdata(c_wdata), .m_size(c_size), .s_rdata(c_s_rdata), .s_datardy(c_s_datardy),
        .m_rdata(c_rdata), .m_datardy(c_datardy), .err_oe_we(c_err_oe_we), .err_oob(c_err_oob)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic a_load(input logic [10:0] ad, input logic [7:0] d);
        a_init_we = 1'b1; a_init_addr = ad; a_init_data = d;
        step();
        a_init_we = 1'b0;
    endtask

    task automatic b_load(input logic [10:0] ad, input logic [7:0] d);
        b_init_we = 1'b1; b_init_addr = ad; b_init_data = d;
        step();
        b_init_we = 1'b0;
    endtask

    task automatic c_load(input logic [10:0] ad, input logic [7:0] d);
        c_init_we = 1'b1; c_init_addr = ad; c_init_data = d;
        step();
        c_init_we = 1'b0;
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        step();
        step();
        #1;
        checks++; if (a_datardy !== 2'b00) begin errors++; $display("FAIL reset_a_rdy: got %b expected 00", a_datardy); end
        checks++; if (a_rdata !== 64'h0) begin errors++; $display("FAIL reset_a_rdata: got %h expected 0", a_rdata); end
        checks++; if (a_err_oe_we !== 2'b00 || a_err_oob !== 2'b00) begin errors++; $display("FAIL reset_a_err: got %b/%b expected 00/00", a_err_oe_we, a_err_oob); end
        checks++; if (b_datardy !== 4'h0 || c_datardy !== 1'b0) begin errors++; $display("FAIL reset_bc_rdy: got %h/%b expected 0/0", b_datardy, c_datardy); end
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        step();
    endtask

    task automatic test_read();
        a_load(11'h10, 8'h11); a_load(11'h11, 8'h22); a_load(11'h12, 8'h33); a_load(11'h13, 8'h44);
        a_oe = 2'b01; a_addr[10:0] = 11'h10; a_size[5:0] = 6'd32;
        #1;
        checks++; if (a_datardy !== 2'b00) begin errors++; $display("FAIL read_c0_rdy: got %b expected 00", a_datardy); end
        step(); #1;
        checks++; if (a_datardy !== 2'b01) begin errors++; $display("FAIL read_c1_rdy: got %b expected 01", a_datardy); end
        checks++; if (a_rdata[31:0] !== 32'h44332211) begin errors++; $display("FAIL read_data: got %h expected 44332211", a_rdata[31:0]); end
        step();
        a_oe = 2'b00;
    endtask

    task automatic test_masked_write();
        a_load(11'h20, 8'hDD); a_load(11'h21, 8'hCC); a_load(11'h22, 8'hBB); a_load(11'h23, 8'hAA);
        a_we = 2'b10; a_addr[21:11] = 11'h20; a_size[11:6] = 6'd8; a_wdata[63:32] = 32'h000000EE;
        #1;
        checks++; if (a_datardy !== 2'b10) begin errors++; $display("FAIL wr_rdy: got %b expected 10", a_datardy); end
        step();
        a_we = 2'b00; a_oe = 2'b10; a_size[11:6] = 6'd32;
        #1;
        checks++; if (a_datardy !== 2'b00) begin errors++; $display("FAIL wr_rb_c0: got %b expected 00", a_datardy); end
        step(); #1;
        checks++; if (a_datardy !== 2'b10 || a_rdata[63:32] !== 32'hAABBCCEE) begin errors++; $display("FAIL wr_readback: got %b %h expected 10 aabbccee", a_datardy, a_rdata[63:32]); end
        step();
        a_oe = 2'b00;
    endtask

    task automatic test_conflict();
        a_we = 2'b11; a_addr = {11'h30, 11'h30}; a_size = {6'd8, 6'd8};
        a_wdata = {32'h00000022, 32'h00000011};
        #1;
        checks++; if (a_datardy !== 2'b11) begin errors++; $display("FAIL conflict_rdy: got %b expected 11", a_datardy); end
        step();
        a_we = 2'b00; a_oe = 2'b01;
        step(); #1;
        checks++; if (a_datardy[0] !== 1'b1 || a_rdata[7:0] !== 8'h22) begin errors++; $display("FAIL conflict_byte: got %b %h expected 1 22", a_datardy[0], a_rdata[7:0]); end
        step();
        a_oe = 2'b00;
    endtask

    task automatic test_boundary();
        a_load(11'd1022, 8'h5A); a_load(11'd1023, 8'hA5);
        a_oe = 2'b01; a_addr[10:0] = 11'd1024; a_size[5:0] = 6'd32;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_datardy !== 2'b00) begin errors++; $display("FAIL oor_rdy[%0d]: got %b expected 00", i, a_datardy); end
            if (i == 2) begin
                checks++; if (a_rdata[31:0] !== 32'h0 || a_err_oob !== 2'b00) begin errors++; $display("FAIL oor_data: got %h oob %b expected 0 oob 00", a_rdata[31:0], a_err_oob); end
            end
            step();
        end
        a_addr[10:0] = 11'd1022;
        #1;
        checks++; if (a_datardy !== 2'b00) begin errors++; $display("FAIL straddle_c0: got %b expected 00", a_datardy); end
        step(); #1;
        checks++; if (a_datardy !== 2'b01 || a_rdata[31:0] !== 32'h0000A55A) begin errors++; $display("FAIL straddle_data: got %b %h expected 01 0000a55a", a_datardy, a_rdata[31:0]); end
        checks++; if (a_err_oob !== 2'b01) begin errors++; $display("FAIL straddle_oob: got %b expected 01", a_err_oob); end
        step();
        a_oe = 2'b00;
    endtask

    task automatic test_oe_we();
        a_load(11'h40, 8'h77); a_load(11'h41, 8'h00); a_load(11'h42, 8'h00); a_load(11'h43, 8'h00);
        a_oe = 2'b01; a_we = 2'b01; a_addr[10:0] = 11'h40; a_size[5:0] = 6'd8; a_wdata[31:0] = 32'h99;
        #1;
        checks++; if (a_datardy !== 2'b00) begin errors++; $display("FAIL oewe_c0: got %b expected 00", a_datardy); end
        step(); #1;
        checks++; if (a_datardy !== 2'b01 || a_rdata[7:0] !== 8'h77) begin errors++; $display("FAIL oewe_read: got %b %h expected 01 77", a_datardy, a_rdata[7:0]); end
        checks++; if (a_err_oe_we !== 2'b01) begin errors++; $display("FAIL oewe_flag: got %b expected 01", a_err_oe_we); end
        step();
        a_we = 2'b00;
        step(); #1;
        checks++; if (a_datardy !== 2'b01 || a_rdata[7:0] !== 8'h77) begin errors++; $display("FAIL oewe_mem: got %b %h expected 01 77", a_datardy, a_rdata[7:0]); end
        checks++; if (a_err_oe_we !== 2'b01) begin errors++; $display("FAIL oewe_sticky: got %b expected 01", a_err_oe_we); end
        step();
        a_oe = 2'b00;
    endtask

    task automatic test_sweep();
        logic [3:0] exp_rdy;
        for (int i = 0; i < 16; i++) b_load(11'(i), 8'(i + 1));
        for (int i = 0; i < 4; i++) b_load(11'(8'h50 + i), 8'h00);
        b_oe = 4'hF;
        b_addr = {11'd12, 11'd8, 11'd4, 11'd0};
        b_size = {6'd32, 6'd32, 6'd32, 6'd32};
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_rdy = ((i % 4) == 3) ? 4'hF : 4'h0;
            checks++; if (b_datardy !== exp_rdy) begin errors++; $display("FAIL sweep_rd_rdy[%0d]: got %h expected %h", i, b_datardy, exp_rdy); end
            if ((i % 4) == 3) begin
                checks++; if (b_rdata !== 128'h100F0E0D_0C0B0A09_08070605_04030201) begin errors++; $display("FAIL sweep_rdata[%0d]: got %h", i, b_rdata); end
            end
            step();
        end
        b_oe = 4'h0;
        b_we = 4'b0100; b_addr[32:22] = 11'h50; b_size[17:12] = 6'd16; b_wdata[95:64] = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_rdy = (i == 2) ? 4'b0100 : 4'h0;
            checks++; if (b_datardy !== exp_rdy) begin errors++; $display("FAIL sweep_wr_rdy[%0d]: got %h expected %h", i, b_datardy, exp_rdy); end
            step();
        end
        b_we = 4'h0; b_oe = 4'b0100; b_size[17:12] = 6'd32;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_rdy = (i == 3) ? 4'b0100 : 4'h0;
            checks++; if (b_datardy !== exp_rdy) begin errors++; $display("FAIL sweep_rb_rdy[%0d]: got %h expected %h", i, b_datardy, exp_rdy); end
            if (i == 3) begin
                checks++; if (b_rdata[95:64] !== 32'h00005678) begin errors++; $display("FAIL sweep_rb_data: got %h expected 00005678", b_rdata[95:64]); end
            end
            step();
        end
        b_oe = 4'h0;
    endtask

    task automatic test_reset_mid();
        c_load(11'h08, 8'h01); c_load(11'h09, 8'h02); c_load(11'h0A, 8'h03); c_load(11'h0B, 8'h04);
        c_oe = 1'b1; c_we = 1'b1; c_addr = 11'h08; c_size = 6'd32;
        #1;
        checks++; if (c_datardy !== 1'b0) begin errors++; $display("FAIL rst_oewe_rdy: got %b expected 0", c_datardy); end
        step();
        c_oe = 1'b0; c_we = 1'b0;
        #1;
        checks++; if (c_err_oe_we !== 1'b1) begin errors++; $display("FAIL rst_flag_set: got %b expected 1", c_err_oe_we); end
        step();
        c_oe = 1'b1;
        #1;
        checks++; if (c_datardy !== 1'b0) begin errors++; $display("FAIL rst_c0: got %b expected 0", c_datardy); end
        step();
        c_reset = 1'b1;
        #1;
        checks++; if (c_datardy !== 1'b0) begin errors++; $display("FAIL rst_cycle_rdy: got %b expected 0", c_datardy); end
        step();
        c_reset = 1'b0;
        #1;
        checks++; if (c_err_oe_we !== 1'b0 || c_datardy !== 1'b0) begin errors++; $display("FAIL rst_after0: got flag %b rdy %b expected 0 0", c_err_oe_we, c_datardy); end
        step(); #1;
        checks++; if (c_datardy !== 1'b0) begin errors++; $display("FAIL rst_after1: got %b expected 0", c_datardy); end
        step(); #1;
        checks++; if (c_datardy !== 1'b1 || c_rdata !== 32'h04030201) begin errors++; $display("FAIL rst_after2: got %b %h expected 1 04030201", c_datardy, c_rdata); end
        step();
        c_oe = 1'b0;
    endtask

    initial begin
        a_reset = 1'b1; a_init_we = 1'b0; a_init_addr = '0; a_init_data = '0;
        a_oe = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_size = '0;
        a_s_rdata = '0; a_s_datardy = '0;
        b_reset = 1'b1; b_init_we = 1'b0; b_init_addr = '0; b_init_data = '0;
        b_oe = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_size = '0;
        b_s_rdata = '0; b_s_datardy = '0;
        c_reset = 1'b1; c_init_we = 1'b0; c_init_addr = '0; c_init_data = '0;
        c_oe = '0; c_we = '0; c_addr = '0; c_wdata = '0; c_size = '0;
        c_s_rdata = '0; c_s_datardy = '0;

        test_reset();
        test_read();
        test_masked_write();
        test_conflict();
        test_boundary();
        test_oe_we();
        test_sweep();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
